seq_mul_param: RTL and testbench

Parametrised sequential shift-add multiplier with per-operation signed/unsigned mode and a start/ready/out_valid handshake. It replaces the fixed 16-bit, reset-loaded lab multiplier. Operands are accepted on a handshake instead of through reset, so back-to-back operations need no reset pulse. It sits between operand registers and the result bus of the datapath labs and is checked against a behavioural `*`.

---
 rtl/seq_mul_pkg.sv | 18 +
 rtl/seq_mul_abs.sv | 15 +
 rtl/seq_mul_param.sv | 133 +++++++++++++
 tb/tb_seq_mul_param.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the parametrised sequential multiplier.
// Holds the FSM state encoding, the default operand width and the counter sizing rule.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 16;

  // The counter must be able to represent WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mul_abs.sv
// Conditional two's-complement negate.
// Gives the magnitude of a signed operand, or applies the sign to an unsigned product.
module seq_mul_abs #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = negate_i ? (WIDTH'(0) - value_i) : value_i;
  end

endmodule

// File: rtl/seq_mul_param.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, LSB first.
// Signed operands are reduced to magnitudes on accept and the sign is reapplied at the end.
module seq_mul_param
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               ready,
  output logic               busy,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]    out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]    result;

  seq_mul_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value_i  (in_a),
    .negate_i (is_signed & in_a[WIDTH-1]),
    .result_o (abs_a)
  );

  seq_mul_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value_i  (in_b),
    .negate_i (is_signed & in_b[WIDTH-1]),
    .result_o (abs_b)
  );

  // A zero magnitude negates to zero, so no -0 artefact can appear.
  seq_mul_abs #(.WIDTH(PW)) u_abs_res (
    .value_i  (acc_q),
    .negate_i (neg_q),
    .result_o (result)
  );

  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mag_a_d = abs_a;
          mag_b_d = abs_b;
          neg_d   = is_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (mag_b_q[0]) begin
          acc_d = acc_q + (PW'(mag_a_q) << cnt_q);
        end
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // out and out_valid are registered together so they change on the same edge.
        out_d       = result;
        out_valid_d = 1'b1;
        if (start) begin
          mag_a_d = abs_a;
          mag_b_d = abs_b;
          neg_d   = is_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    ready     = (state_q == StIdle) || (state_q == StDone);
    busy      = (state_q == StCalc);
    out       = out_q;
    out_valid = out_valid_q;
  end

endmodule

// File: tb/tb_seq_mul_param.sv
// Scoreboard bench for seq_mul_param at WIDTH 16, 4 and 32.
// Issuers push expected products and arrival cycles; per-instance monitors pop and compare.
module tb_seq_mul_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [63:0] val;
    int unsigned t;
  } exp_t;

  exp_t q[3][$];

  logic        start_s[3];
  logic        sign_s[3];
  logic [31:0] a_s[3];
  logic [31:0] b_s[3];
  logic        ready_s[3];
  logic        busy_s[3];
  logic        valid_s[3];
  logic [31:0] o16;
  logic [7:0]  o4;
  logic [63:0] o32;
  logic [63:0] out_s[3];

  always_comb begin
    out_s[0] = {32'b0, o16};
    out_s[1] = {56'b0, o4};
    out_s[2] = o32;
  end

  seq_mul_param #(.WIDTH(16)) u_dut16 (
    .CLK(clk), .reset_n(rst_n), .start(start_s[0]), .is_signed(sign_s[0]),
    .in_a(a_s[0][15:0]), .in_b(b_s[0][15:0]), .ready(ready_s[0]), .busy(busy_s[0]),
    .out(o16), .out_valid(valid_s[0])
  );

  seq_mul_param #(.WIDTH(4)) u_dut4 (
    .CLK(clk), .reset_n(rst_n), .start(start_s[1]), .is_signed(sign_s[1]),
    .in_a(a_s[1][3:0]), .in_b(b_s[1][3:0]), .ready(ready_s[1]), .busy(busy_s[1]),
    .out(o4), .out_valid(valid_s[1])
  );

  seq_mul_param #(.WIDTH(32)) u_dut32 (
    .CLK(clk), .reset_n(rst_n), .start(start_s[2]), .is_signed(sign_s[2]),
    .in_a(a_s[2]), .in_b(b_s[2]), .ready(ready_s[2]), .busy(busy_s[2]),
    .out(o32), .out_valid(valid_s[2])
  );

  function automatic int unsigned wid(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 32);
  endfunction

  function automatic logic [63:0] pmask(input int k);
    if (wid(k) == 32) return '1;
    return (64'd1 << (2 * wid(k))) - 64'd1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      if (rst_n && valid_s[k]) begin
        if (q[k].size() == 0) begin
          chk($sformatf("spurious_valid_k%0d", k), {63'b0, valid_s[k]}, 64'd0);
        end else begin
          e = q[k].pop_front();
          chk($sformatf("product_k%0d", k), out_s[k], e.val);
          chk($sformatf("latency_k%0d", k), 64'(cyc), 64'(e.t));
        end
      end
    end
  end

  // Holds start high until accepted; leaves start asserted for back-to-back use.
  task automatic issue(input int k, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] want, output int unsigned acc_cyc);
    int n;
    n = 0;
    acc_cyc = 0;
    @(negedge clk);
    start_s[k] = 1'b1;
    sign_s[k]  = s;
    a_s[k]     = a;
    b_s[k]     = b;
    while (!ready_s[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_s[k]) begin
      chk("issue_ready", {63'b0, ready_s[k]}, 64'd1);
    end else begin
      acc_cyc = cyc + 1;
      q[k].push_back('{val: want & pmask(k), t: cyc + wid(k) + 2});
    end
    @(posedge clk);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    start_s[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (q[k].size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q[k].size() != 0) begin
      chk("drain", 64'(q[k].size()), 64'd0);
      q[k].delete();
    end
  endtask

  task automatic directed16();
    int unsigned c0, c1, c2;
    issue(0, 1'b1, 32'd3, 32'd9, 64'd27, c0);
    idle(0);
    drain(0);
    issue(0, 1'b1, 32'd0, 32'd11, 64'd0, c0);
    issue(0, 1'b1, 32'hD8EF, 32'h000E, 64'hFFFDDD12, c0);
    issue(0, 1'b1, 32'h007B, 32'hFFF9, 64'hFFFFFCA3, c0);
    issue(0, 1'b1, 32'hFFFF, 32'hFFC4, 64'h3C, c0);
    issue(0, 1'b1, 32'h8000, 32'h8000, 64'h40000000, c0);
    issue(0, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001, c0);
    issue(0, 1'b1, 32'hFFFF, 32'h0002, 64'hFFFFFFFE, c0);
    issue(0, 1'b0, 32'hFFFF, 32'h0002, 64'h0001FFFE, c0);
    idle(0);
    drain(0);
    // Three operations with start held: accepts must be exactly 17 cycles apart.
    issue(0, 1'b1, 32'd7, 32'd6, 64'd42, c0);
    issue(0, 1'b0, 32'h1234, 32'h0010, 64'h12340, c1);
    issue(0, 1'b1, 32'hFFFE, 32'h0003, 64'hFFFFFFFA, c2);
    idle(0);
    drain(0);
    chk("throughput_1", 64'(c1 - c0), 64'd17);
    chk("throughput_2", 64'(c2 - c1), 64'd17);
    // A start pulse while busy must be ignored.
    issue(0, 1'b1, 32'd5, 32'd7, 64'd35, c0);
    idle(0);
    repeat (3) @(negedge clk);
    chk("busy_mid_calc", {63'b0, busy_s[0]}, 64'd1);
    start_s[0] = 1'b1;
    a_s[0] = 32'd100;
    b_s[0] = 32'd100;
    @(negedge clk);
    start_s[0] = 1'b0;
    drain(0);
    repeat (20) @(negedge clk);
    chk("out_hold", out_s[0], 64'd35);
  endtask

  task automatic sweep4();
    int unsigned c;
    int sa, sb;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        issue(1, 1'b1, 32'(a), 32'(b), 64'(longint'(sa * sb)), c);
        issue(1, 1'b0, 32'(a), 32'(b), 64'(a * b), c);
      end
    end
    idle(1);
    drain(1);
  endtask

  task automatic sweep32();
    int unsigned c;
    logic [31:0] a, b;
    issue(2, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, c);
    issue(2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, c);
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      issue(2, 1'b1, a, b, 64'(longint'($signed(a)) * longint'($signed(b))), c);
      issue(2, 1'b0, a, b, {32'b0, a} * {32'b0, b}, c);
    end
    idle(2);
    drain(2);
  endtask

  initial begin
    int unsigned c;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      sign_s[k]  = 1'b0;
      a_s[k]     = '0;
      b_s[k]     = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'b0, ready_s[0]}, 64'd1);
    chk("rst_busy", {63'b0, busy_s[0]}, 64'd0);
    chk("rst_out", out_s[0], 64'd0);
    chk("rst_valid", {63'b0, valid_s[0]}, 64'd0);
    rst_n = 1'b1;

    fork
      directed16();
      sweep4();
      sweep32();
    join

    // Asynchronous reset in the middle of CALC abandons the operation.
    issue(0, 1'b1, 32'd200, 32'd300, 64'd60000, c);
    idle(0);
    repeat (6) @(negedge clk);
    chk("calc_busy", {63'b0, busy_s[0]}, 64'd1);
    chk("calc_ready", {63'b0, ready_s[0]}, 64'd0);
    rst_n = 1'b0;
    #1;
    q[0].delete();
    chk("arst_ready", {63'b0, ready_s[0]}, 64'd1);
    chk("arst_busy", {63'b0, busy_s[0]}, 64'd0);
    chk("arst_out", out_s[0], 64'd0);
    chk("arst_valid", {63'b0, valid_s[0]}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_out", out_s[0], 64'd0);
    issue(0, 1'b1, 32'hFFFB, 32'd9, 64'hFFFFFFD3, c);
    idle(0);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
